// File: rtl/smart_vending.sv
// rtl/smart_vending.sv - product request synchronizer, priority encoder and debouncer
//
// Purpose: turns four asynchronous product request lines into a stable,
// registered 2-bit product code for the dispense/pricing logic.
//
// Ports:
//   clk        in   system clock, rising edge active
//   rst_n      in   asynchronous active-low reset
//   P[3:0]     in   product request lines (async to clk), P[3] highest priority
//   S[1:0]     out  selected product code (registered)
//   sel_valid  out  S represents an active request
//   sel_change out  one-cycle pulse after {sel_valid,S} takes a new value
module smart_vending #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] P,
  output logic [1:0] S,
  output logic       sel_valid,
  output logic       sel_change
);

  localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  // Synchronizer chain, stage 0 in the low nibble, oldest stage in the high nibble.
  logic [SYNC_STAGES*4-1:0] sync_q, sync_d;
  logic [3:0]               p_sync;

  logic [1:0]    cand_code;
  logic          cand_valid;
  logic [2:0]    cand;
  logic [2:0]    last_cand_q, last_cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;        // {sel_valid, S}
  logic          change_q, change_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES*4-5:0], P};
    p_sync = sync_q[SYNC_STAGES*4-1 -: 4];
  end

  always_comb begin
    cand_code = 2'd0;
    if (p_sync[3])      cand_code = 2'd3;
    else if (p_sync[2]) cand_code = 2'd2;
    else if (p_sync[1]) cand_code = 2'd1;
    else                cand_code = 2'd0;
    cand_valid = |p_sync;
    cand       = {cand_valid, cand_code};
  end

  always_comb begin
    last_cand_d = cand;
    // Any change of the candidate restarts the stability count at 1.
    if (cand != last_cand_q)    cnt_d = CNT_ONE;
    else if (cnt_q != CNT_MAX)  cnt_d = cnt_q + CNT_ONE;
    else                        cnt_d = cnt_q;

    sel_d    = sel_q;
    change_d = 1'b0;
    // While the count stays saturated the same value is reloaded every
    // clock; only a genuinely different value raises the strobe.
    if (cnt_d == CNT_MAX) begin
      sel_d    = cand;
      change_d = (cand != sel_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      last_cand_q <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      change_q    <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      last_cand_q <= last_cand_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      change_q    <= change_d;
    end
  end

  assign S          = sel_q[1:0];
  assign sel_valid  = sel_q[2];
  assign sel_change = change_q;

endmodule

// File: tb/tb_smart_vending.sv
// tb/tb_smart_vending.sv - self-checking bench for smart_vending
module tb_smart_vending;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] P;
  logic [1:0] S;
  logic       sel_valid;
  logic       sel_change;

  smart_vending #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .P          (P),
    .S          (S),
    .sel_valid  (sel_valid),
    .sel_change (sel_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] p);
    if (p[3])      return 2'd3;
    else if (p[2]) return 2'd2;
    else if (p[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  // Model: the candidate seen at an edge is the request sampled SYNC edges
  // earlier (zero right after reset); a selection is taken once the same
  // candidate has been seen on DEB consecutive edges since reset.
  logic [3:0] ph[$];
  logic [3:0] m_ps;
  logic [2:0] m_c, m_prev;
  int         m_run = 0;
  int         m_edges = 0;
  logic [1:0] exp_s = 2'd0;
  logic       exp_v = 1'b0;
  logic       exp_c = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph.delete();
      m_run   = 0;
      m_edges = 0;
      exp_s   = 2'd0;
      exp_v   = 1'b0;
      exp_c   = 1'b0;
    end else begin
      m_ps = (ph.size() >= SYNC) ? ph[0] : 4'b0000;
      ph.push_back(P);
      if (ph.size() > SYNC) void'(ph.pop_front());
      m_c = {|m_ps, enc(m_ps)};
      if (m_edges == 0 || m_c != m_prev) m_run = 1;
      else if (m_run < DEB) m_run++;
      m_prev = m_c;
      m_edges++;
      if (m_run >= DEB) begin
        exp_c = (m_c != {exp_v, exp_s});
        {exp_v, exp_s} = m_c;
      end else begin
        exp_c = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_S", int'(S), int'(exp_s));
      chk("cmp_sel_valid", int'(sel_valid), int'(exp_v));
      chk("cmp_sel_change", int'(sel_change), int'(exp_c));
    end
    if (sel_change === 1'b1) pulses++;
  end

  task automatic drive(input logic [3:0] p);
    @(negedge clk);
    #2;
    P = p;
    pulses = 0;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset release followed by the full latency, P held at 4'b1111.
  task automatic latency_check(input string name, input int code);
    repeat (SYNC + DEB - 1) @(posedge clk);
    #1;
    chk({name, "_pre_valid"}, int'(sel_valid), 0);
    @(posedge clk);
    #1;
    chk({name, "_S"}, int'(S), code);
    chk({name, "_valid"}, int'(sel_valid), 1);
    chk({name, "_change"}, int'(sel_change), 1);
  endtask

  logic [3:0] sweep_p [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
  int         sweep_s [4] = '{0, 1, 2, 3};

  initial begin
    rst_n = 1'b0;
    P     = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("rst_S", int'(S), 0);
    chk("rst_valid", int'(sel_valid), 0);
    chk("rst_change", int'(sel_change), 0);

    @(negedge clk);
    #2;
    rst_n = 1'b1;
    latency_check("reset_release", 3);

    // Thermometer sweep
    for (int i = 0; i < 4; i++) begin
      drive(sweep_p[i]);
      hold(10);
      chk($sformatf("sweep%0d_S", i), int'(S), sweep_s[i]);
      chk($sformatf("sweep%0d_valid", i), int'(sel_valid), 1);
      chk($sformatf("sweep%0d_pulses", i), pulses, 1);
    end

    // Priority with gaps
    drive(4'b1010); hold(10);
    chk("prio_1010_S", int'(S), 3);
    chk("prio_1010_pulses", pulses, 0);
    drive(4'b0100); hold(10);
    chk("prio_0100_S", int'(S), 2);
    chk("prio_0100_pulses", pulses, 1);
    drive(4'b0101); hold(10);
    chk("prio_0101_S", int'(S), 2);
    chk("prio_0101_pulses", pulses, 0);

    // Release from S = 2
    drive(4'b0000);
    repeat (SYNC + DEB - 1) @(posedge clk);
    #1;
    chk("release_pre_valid", int'(sel_valid), 1);
    @(posedge clk);
    #1;
    chk("release_valid", int'(sel_valid), 0);
    chk("release_S", int'(S), 0);
    chk("release_change", int'(sel_change), 1);
    hold(6);
    chk("release_pulses", pulses, 1);

    // Glitch rejection
    drive(4'b0010); hold(10);
    chk("glitch_base_S", int'(S), 1);
    drive(4'b1000);
    repeat (2) @(posedge clk);
    #2;
    P = 4'b0010;
    hold(10);
    chk("glitch2_S", int'(S), 1);
    chk("glitch2_pulses", pulses, 0);

    drive(4'b1000);
    repeat (4) @(posedge clk);
    #2;
    P = 4'b0010;
    repeat (2) @(posedge clk);
    #1;
    chk("glitch4_S_hi", int'(S), 3);
    repeat (4) @(posedge clk);
    #1;
    chk("glitch4_S_back", int'(S), 1);
    hold(4);
    chk("glitch4_pulses", pulses, 2);

    // Mid-operation asynchronous reset during a debounce count
    drive(4'b1000);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_S", int'(S), 0);
    chk("midrst_valid", int'(sel_valid), 0);
    chk("midrst_change", int'(sel_change), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    latency_check("midrst_release", 3);
    hold(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/smart_vending.md
Name: smart_vending

Overview:
- Product-selection front end of the smart vending machine.
- Four active-high product request lines P[3:0] are synchronized, debounced and priority-encoded.
- P[3] has the highest priority.
- Outputs: registered 2-bit product code S, plus a valid flag and a one-cycle change strobe.
- Feeds the dispense/pricing logic downstream.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages in the input synchronizer (legal values ≥ 2).
- DEBOUNCE_CYCLES, 4, consecutive clocks the encoded request must stay identical before S/sel_valid update (legal values ≥ 1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- P  input  4  product request lines, asynchronous to clk; bit i requests product i.
- S  output  2  selected product code, registered.
- sel_valid  output  1  high when S represents an active request.
- sel_change  output  1  one-clock pulse when {sel_valid,S} changes.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous release):
  - All synchronizer flops, debounce counter and candidate register clear.
  - S = 2'b00, sel_valid = 0, sel_change = 0.
- Synchronizer: P passes through a SYNC_STAGES-deep flop chain per bit, giving p_sync.
- Priority encode (combinational on p_sync), producing cand_code and cand_valid:
  - p_sync[3] = 1 → 3
  - else p_sync[2] = 1 → 2
  - else p_sync[1] = 1 → 1
  - else p_sync[0] = 1 → 0
  - cand_valid = |p_sync.
  - p_sync = 0 → cand_code = 0, cand_valid = 0.
  - Lower bits are don't-care once a higher bit is set, e.g. 4'b0011 → 1, 4'b1111 → 3, 4'b1010 → 3.
- Debounce:
  - The register last_cand holds {cand_valid,cand_code} from the previous clock.
  - If the current {cand_valid,cand_code} differs from last_cand, the counter loads 1.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES.
  - When the counter reaches DEBOUNCE_CYCLES, {sel_valid,S} is loaded with the candidate on that edge.
  - The counter is sized by clog2(DEBOUNCE_CYCLES+1).
- Latency:
  - P is held stable from before rising edge 1 (relative to the change).
  - S/sel_valid show the new value after edge SYNC_STAGES + DEBOUNCE_CYCLES.
  - Default: 6 clocks. The value holds while P stays stable.
- Glitches: a request change lasting fewer than DEBOUNCE_CYCLES synchronized clocks never reaches S. S keeps its previous value.
- sel_change:
  - Registered; high for exactly the one cycle immediately after {sel_valid,S} takes a new value.
  - Reloading an identical value produces no pulse.
- Request release: when all P bits drop and the drop is debounced, sel_valid goes to 0 and S goes to 2'b00. sel_change pulses once.
- Simultaneous requests: resolved purely by priority. There is no history or latching of lower bits.
- Reset mid-operation: outputs clear immediately and asynchronously. After release, the full latency applies again before any selection appears.
- No combinational path from P to any output.

Test Plan:
- Reset: rst_n = 0 with P = 4'b1111 → S = 0, sel_valid = 0, sel_change = 0 immediately. After release with P = 4'b1111 held, S = 3 and sel_valid = 1 exactly 6 clocks later.
- Thermometer sweep, each value held 10 clocks: P = 4'b0001 → S = 0; 4'b0011 → S = 1; 4'b0111 → S = 2; 4'b1111 → S = 3. sel_valid = 1 throughout; one sel_change pulse per step.
- Priority with gaps: P = 4'b1010 → S = 3; P = 4'b0100 → S = 2; P = 4'b0101 → S = 2 with no sel_change on that transition.
- Glitch rejection: from stable S = 1 (P = 4'b0010), pulse P = 4'b1000 for 2 clocks → S stays 1, no sel_change. A 4-clock pulse of the same value → S = 3 for its duration, then back to 1.
- Release: from S = 2, P = 4'b0000 → after 6 clocks sel_valid = 0, S = 0, one sel_change pulse.
- Mid-operation reset: assert rst_n low asynchronously (between clock edges) during a debounce count → outputs clear at once. Counter restarts after release, with no stale update.
